// File: rtl/voice_match_scorer_pkg.sv
// ---------------------------------------------------------------------------
// voice_match_scorer_pkg
//   Shared definitions for the voice-recognition match datapath.
//   - voice_state_e : states of the template-scoring controller
//   - WORD_BYTES    : bytes compared per 32-bit word by the threshold comparator
//   - COUNT_W       : width of the comparator's per-word match count (0..4)
//   - score_width() : width of an unsigned score that can hold WORD_BYTES*words
// ---------------------------------------------------------------------------
package voice_match_scorer_pkg;

    localparam int WORD_BYTES = 4;
    localparam int COUNT_W    = $clog2(WORD_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CMP,
        FIN
    } voice_state_e;

    // The maximum score is WORD_BYTES*words, so this width can never overflow.
    function automatic int score_width(input int words);
        return $clog2(WORD_BYTES * words + 1);
    endfunction

endpackage

// File: rtl/voice_match_scorer_addr_gen.sv
// ---------------------------------------------------------------------------
// voice_match_scorer_addr_gen
//   Word/template counters and the paired read addresses for the scorer.
//   Addresses are pure functions of the counters, and the counters only move
//   on entry to or inside a RUN phase, so both addresses hold their last
//   value while the controller is elsewhere.
//
//   Ports:
//     clk, rst_l   clock, asynchronous active-low reset
//     clear        restart at word 0 / template 0 (accepted start)
//     word_inc     advance to the next word of the current template
//     tmpl_inc     advance to the next template, word back to 0
//     tmpl         current template index
//     word_last    current word is WORDS-1
//     tmpl_last    current template is NUM_TEMPLATES-1
//     ram_addr     sample word address
//     dir_addr     dictionary address tmpl*WORDS + word
// ---------------------------------------------------------------------------
module voice_match_scorer_addr_gen #(
    parameter  int WORDS         = 256,
    parameter  int NUM_TEMPLATES = 8,
    localparam int AW            = $clog2(WORDS),
    localparam int TW            = $clog2(NUM_TEMPLATES),
    localparam int DW            = $clog2(WORDS * NUM_TEMPLATES)
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          clear,
    input  logic          word_inc,
    input  logic          tmpl_inc,
    output logic [TW-1:0] tmpl,
    output logic          word_last,
    output logic          tmpl_last,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] dir_addr
);

    logic [AW-1:0] word_reg;
    logic [TW-1:0] tmpl_reg;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            word_reg <= '0;
            tmpl_reg <= '0;
        end else if (clear) begin
            word_reg <= '0;
            tmpl_reg <= '0;
        end else if (tmpl_inc) begin
            word_reg <= '0;
            tmpl_reg <= tmpl_reg + 1'b1;
        end else if (word_inc) begin
            word_reg <= word_reg + 1'b1;
        end
    end

    assign tmpl      = tmpl_reg;
    assign word_last = (word_reg == AW'(WORDS - 1));
    assign tmpl_last = (tmpl_reg == TW'(NUM_TEMPLATES - 1));
    assign ram_addr  = word_reg;

    // A power-of-two template length turns the multiply-add into wiring.
    generate
        if ((WORDS & (WORDS - 1)) == 0) begin : g_pow2
            assign dir_addr = DW'({tmpl_reg, word_reg});
        end else begin : g_mul
            assign dir_addr = DW'(tmpl_reg) * DW'(WORDS) + DW'(word_reg);
        end
    endgenerate

endmodule

// File: rtl/voice_match_scorer.sv
// ---------------------------------------------------------------------------
// voice_match_scorer
//   Scores one captured sample against every dictionary template. For each
//   template it walks all words, issuing paired RAM/ROM read addresses, and
//   accumulates the comparator's per-word match count (add_val, one cycle
//   behind the address). The best template (lowest index on ties) is reported
//   with a one-cycle done pulse.
//
//   Optional feature (macro VOICE_MIN_SCORE_EN): when defined, match_valid is
//   only raised if the best score reaches MIN_SCORE; otherwise match_valid is
//   raised unconditionally at the end of a run.
//
//   Ports:
//     clk, rst_l   clock, asynchronous active-low reset (aborts a run)
//     start        begin a run; only looked at while idle
//     ram_addr     sample word address
//     dir_addr     template word address (tmpl*WORDS + word)
//     add_val      comparator match count for the previous cycle's addresses
//     busy         run in progress (drops together with the done pulse)
//     done         one-cycle pulse, results final
//     best_idx     winning template
//     best_score   winning score
//     match_valid  best_idx is an accepted match
// ---------------------------------------------------------------------------
module voice_match_scorer
    import voice_match_scorer_pkg::*;
#(
    parameter  int WORDS         = 256,
    parameter  int NUM_TEMPLATES = 8,
    parameter  int MIN_SCORE     = 512,
    localparam int AW            = $clog2(WORDS),
    localparam int DW            = $clog2(WORDS * NUM_TEMPLATES),
    localparam int TW            = $clog2(NUM_TEMPLATES),
    localparam int SW            = score_width(WORDS)
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               start,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      dir_addr,
    input  logic [COUNT_W-1:0] add_val,
    output logic               busy,
    output logic               done,
    output logic [TW-1:0]      best_idx,
    output logic [SW-1:0]      best_score,
    output logic               match_valid
);

`ifdef VOICE_MIN_SCORE_EN
    localparam bit MIN_GATE_EN = 1'b1;
`else
    localparam bit MIN_GATE_EN = 1'b0;
`endif
    localparam logic [31:0] MIN_SCORE_U = 32'(MIN_SCORE);

    voice_state_e  state_reg;
    logic [SW-1:0] score_reg;
    logic [SW-1:0] best_score_reg;
    logic [TW-1:0] best_idx_reg;
    logic          match_valid_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          pipe_valid_reg;   // previous cycle was RUN, so add_val is live

    logic [TW-1:0] tmpl;
    logic          word_last;
    logic          tmpl_last;
    logic          take_new;
    logic [SW-1:0] cmp_best;
    logic          min_ok;

    voice_match_scorer_addr_gen #(
        .WORDS         (WORDS),
        .NUM_TEMPLATES (NUM_TEMPLATES)
    ) u_addr_gen (
        .clk       (clk),
        .rst_l     (rst_l),
        .clear     ((state_reg == IDLE) && start),
        .word_inc  ((state_reg == RUN) && !word_last),
        .tmpl_inc  ((state_reg == CMP) && !tmpl_last),
        .tmpl      (tmpl),
        .word_last (word_last),
        .tmpl_last (tmpl_last),
        .ram_addr  (ram_addr),
        .dir_addr  (dir_addr)
    );

    // Template 0 always seeds the best; afterwards only a strictly higher
    // score replaces it, so ties keep the lower index.
    assign take_new = (score_reg > best_score_reg) || (tmpl == '0);
    assign cmp_best = take_new ? score_reg : best_score_reg;
    assign min_ok   = !MIN_GATE_EN || (32'(cmp_best) >= MIN_SCORE_U);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg       <= IDLE;
            score_reg       <= '0;
            best_score_reg  <= '0;
            best_idx_reg    <= '0;
            match_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            pipe_valid_reg  <= 1'b0;
        end else begin
            done_reg       <= 1'b0;
            pipe_valid_reg <= (state_reg == RUN);
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        score_reg       <= '0;
                        best_score_reg  <= '0;
                        best_idx_reg    <= '0;
                        match_valid_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                        state_reg       <= RUN;
                    end
                end
                RUN: begin
                    // First RUN cycle of a template has no read in flight yet.
                    if (pipe_valid_reg) begin
                        score_reg <= score_reg + SW'(add_val);
                    end
                    if (word_last) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    score_reg <= score_reg + SW'(add_val);
                    state_reg <= CMP;
                end
                CMP: begin
                    if (take_new) begin
                        best_score_reg <= score_reg;
                        best_idx_reg   <= tmpl;
                    end
                    score_reg <= '0;
                    if (tmpl_last) begin
                        // Results, done and the falling busy all appear in FIN.
                        match_valid_reg <= min_ok;
                        done_reg        <= 1'b1;
                        busy_reg        <= 1'b0;
                        state_reg       <= FIN;
                    end else begin
                        state_reg <= RUN;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign best_idx    = best_idx_reg;
    assign best_score  = best_score_reg;
    assign match_valid = match_valid_reg;

endmodule

// File: tb/tb_voice_match_scorer.sv
// ---------------------------------------------------------------------------
// tb_voice_match_scorer
//   Drives voice_match_scorer (WORDS=4, NUM_TEMPLATES=3, MIN_SCORE=10) from a
//   dictionary image of per-word comparator results, feeding add_val one
//   cycle after each dictionary address, and compares every cycle of each run
//   against scores computed directly from the image.
// ---------------------------------------------------------------------------
module tb_voice_match_scorer;

    localparam int W   = 4;
    localparam int NT  = 3;
    localparam int MIN = 10;
    localparam int LAT = NT * (W + 2) + 1;   // cycle in which done is high

`ifdef VOICE_MIN_SCORE_EN
    localparam bit MV_GATE = 1'b1;
`else
    localparam bit MV_GATE = 1'b0;
`endif

    logic       clk;
    logic       rst_l;
    logic       start;
    logic [1:0] ram_addr;
    logic [3:0] dir_addr;
    logic [2:0] add_val;
    logic       busy;
    logic       done;
    logic [1:0] best_idx;
    logic [4:0] best_score;
    logic       match_valid;

    int checks   = 0;
    int failures = 0;

    // Comparator result for each dictionary word address.
    logic [2:0] mem [0:15];

    voice_match_scorer #(
        .WORDS         (W),
        .NUM_TEMPLATES (NT),
        .MIN_SCORE     (MIN)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .start       (start),
        .ram_addr    (ram_addr),
        .dir_addr    (dir_addr),
        .add_val     (add_val),
        .busy        (busy),
        .done        (done),
        .best_idx    (best_idx),
        .best_score  (best_score),
        .match_valid (match_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic fill_per_tmpl(input int v0, input int v1, input int v2);
        for (int i = 0; i < 16; i++) mem[i] = 3'd0;
        for (int w = 0; w < W; w++) begin
            mem[0 * W + w] = 3'(v0);
            mem[1 * W + w] = 3'(v1);
            mem[2 * W + w] = 3'(v2);
        end
    endtask

    task automatic fill_random(input int maxv);
        for (int i = 0; i < 16; i++) mem[i] = 3'($urandom_range(0, maxv));
    endtask

    // Sum each template, keep the first maximum.
    task automatic model(output int bidx, output int bscore);
        int s;
        bidx   = 0;
        bscore = -1;
        for (int t = 0; t < NT; t++) begin
            s = 0;
            for (int w = 0; w < W; w++) s += int'(mem[t * W + w]);
            if (s > bscore) begin
                bscore = s;
                bidx   = t;
            end
        end
    endtask

    // Cycle 0 is the cycle start is sampled in; cycles 1..LAT+1 are checked.
    task automatic run_pass(input string tag, input bit hold_start, input bit already_started);
        int         exp_idx;
        int         exp_score;
        bit         exp_mv;
        logic [3:0] prev_addr;
        int         t;
        int         p;
        int         w;
        model(exp_idx, exp_score);
        exp_mv    = MV_GATE ? (exp_score >= MIN) : 1'b1;
        prev_addr = '0;
        if (!already_started) begin
            @(negedge clk);
            start = 1'b1;
        end
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            add_val   = mem[prev_addr];
            prev_addr = dir_addr;
            check($sformatf("%s busy c%0d", tag, k), 32'(busy), 32'(k < LAT));
            check($sformatf("%s done c%0d", tag, k), 32'(done), 32'(k == LAT));
            if (k < LAT) begin
                t = (k - 1) / (W + 2);
                p = (k - 1) % (W + 2);
                w = (p < W) ? p : W - 1;
                check($sformatf("%s ram_addr c%0d", tag, k), 32'(ram_addr), 32'(w));
                check($sformatf("%s dir_addr c%0d", tag, k), 32'(dir_addr), 32'(t * W + w));
            end else begin
                check($sformatf("%s best_idx c%0d", tag, k), 32'(best_idx), 32'(exp_idx));
                check($sformatf("%s best_score c%0d", tag, k), 32'(best_score), 32'(exp_score));
                check($sformatf("%s match_valid c%0d", tag, k), 32'(match_valid), 32'(exp_mv));
            end
        end
        $display("run %s: best_idx=%0d best_score=%0d match_valid=%0b (model %0d/%0d/%0b)",
                 tag, best_idx, best_score, match_valid, exp_idx, exp_score, exp_mv);
    endtask

    initial begin
        start   = 1'b0;
        add_val = 3'd0;
        rst_l   = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 3'd0;

        // Power-on reset.
        #2 rst_l = 1'b0;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset best_idx", 32'(best_idx), 32'd0);
        check("reset best_score", 32'(best_score), 32'd0);
        check("reset match_valid", 32'(match_valid), 32'd0);
        check("reset ram_addr", 32'(ram_addr), 32'd0);
        check("reset dir_addr", 32'(dir_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);

        // Every template perfect: tie resolved to template 0.
        fill_per_tmpl(4, 4, 4);
        run_pass("const4", 1'b0, 1'b0);

        // Per-template counts 1/4/2: template 1 wins with 16.
        fill_per_tmpl(1, 4, 2);
        run_pass("by_tmpl", 1'b0, 1'b0);

        // Tie between templates 1 and 2 keeps 1.
        fill_per_tmpl(2, 3, 3);
        run_pass("tie12", 1'b0, 1'b0);

        // Score 8 and 12 straddle the minimum-score threshold.
        fill_per_tmpl(2, 2, 2);
        run_pass("min_below", 1'b0, 1'b0);
        fill_per_tmpl(3, 3, 3);
        run_pass("min_above", 1'b0, 1'b0);

        // Randomised dictionaries, including out-of-range counts 5..7.
        for (int r = 0; r < 4; r++) begin
            fill_random(4);
            run_pass($sformatf("rand%0d", r), 1'b0, 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            fill_random(7);
            run_pass($sformatf("rand_wide%0d", r), 1'b0, 1'b0);
        end

        // Reset in the middle of template 1 aborts the run.
        fill_per_tmpl(4, 1, 1);
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start   = 1'b0;
            add_val = 3'd4;
        end
        #2 rst_l = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort best_idx", 32'(best_idx), 32'd0);
        check("abort best_score", 32'(best_score), 32'd0);
        check("abort match_valid", 32'(match_valid), 32'd0);
        check("abort ram_addr", 32'(ram_addr), 32'd0);
        check("abort dir_addr", 32'(dir_addr), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;
        for (int k = 0; k < LAT + 5; k++) begin
            @(negedge clk);
            check($sformatf("post_abort done c%0d", k), 32'(done), 32'd0);
            check($sformatf("post_abort busy c%0d", k), 32'(busy), 32'd0);
        end
        fill_random(4);
        run_pass("after_abort", 1'b0, 1'b0);

        // start held high: one run, then a second accepted from the IDLE cycle.
        fill_per_tmpl(1, 2, 4);
        run_pass("hold_first", 1'b1, 1'b0);
        run_pass("hold_second", 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
